// File: rtl/sys1_video_pkg.sv
// Shared 3:3:2 video types, fade FSM states and the dim shift helper.
// Pure declarations: no latency, no backpressure.
package sys1_video_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_WAIT,
        FS_FADE,
        FS_DIMMED
    } fade_state_t;

    // 10 s of user pause at 48 MHz before the fade begins
    localparam logic [31:0] DIM_CYCLES_DEFAULT = 32'd480_000_000;

    // Each component is shifted on its own so bits never bleed across fields
    function automatic rgb332_t rgb332_shr(input rgb332_t p, input logic [1:0] sh);
        rgb332_t o;
        o.r = p.r >> sh;
        o.g = p.g >> sh;
        o.b = p.b >> sh;
        return o;
    endfunction

endpackage

// File: rtl/pause_dim_ctrl_if.sv
// Video bus into and out of the pause/dim stage: pixel enable, RGB332 and timing.
// Master drives the source side and observes the output side; no backpressure.
interface pause_dim_ctrl_if;
    import sys1_video_pkg::*;

    logic    ce_pix;
    rgb332_t rgb_in;
    logic    hblank_in;
    logic    vblank_in;
    logic    hs_in;
    logic    vs_in;

    rgb332_t rgb_out;
    logic    hblank_out;
    logic    vblank_out;
    logic    hs_out;
    logic    vs_out;

    modport master (
        output ce_pix, rgb_in, hblank_in, vblank_in, hs_in, vs_in,
        input  rgb_out, hblank_out, vblank_out, hs_out, vs_out
    );

    modport slave (
        input  ce_pix, rgb_in, hblank_in, vblank_in, hs_in, vs_in,
        output rgb_out, hblank_out, vblank_out, hs_out, vs_out
    );

endinterface

// File: rtl/rgb332_dim.sv
// Per-component right shift of an RGB332 pixel, registered with its timing bits.
// Latency one ce cycle; outputs hold while ce is low; no backpressure.
module rgb332_dim
    import sys1_video_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [1:0] shift,
    input  rgb332_t    rgb_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic       hs_in,
    input  logic       vs_in,
    output rgb332_t    rgb_out,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       hs_out,
    output logic       vs_out
);

    rgb332_t rgb_q, rgb_d;
    logic    hblank_q, hblank_d;
    logic    vblank_q, vblank_d;
    logic    hs_q, hs_d;
    logic    vs_q, vs_d;

    always_comb begin
        rgb_d    = rgb_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        if (ce) begin
            rgb_d    = rgb332_shr(rgb_in, shift);
            hblank_d = hblank_in;
            vblank_d = vblank_in;
            hs_d     = hs_in;
            vs_d     = vs_in;
        end
    end

    // Blanking resets asserted so downstream never sees a visible garbage pixel
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q    <= '0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign hblank_out = hblank_q;
    assign vblank_out = vblank_q;
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// User pause toggle merged with hiscore/OSD pause; fades video after a long user pause.
// Pause is combinational; video latency one ce_pix; no backpressure.
module pause_dim_ctrl
    import sys1_video_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES  = DIM_CYCLES_DEFAULT,
    parameter int          FADE_FRAMES = 8,
    parameter int          MAX_DIM     = 2
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             pause_btn,
    input  logic             hs_access,
    input  logic             osd_status,
    input  logic             osd_pause_en,
    pause_dim_ctrl_if.slave  vid,
    output logic             pause,
    output logic [1:0]       dim_level
);

    localparam int          FCW       = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FCW-1:0] FADE_LAST = FCW'(FADE_FRAMES - 1);
    localparam logic [1:0]  MAX_DIM_L = 2'(MAX_DIM);

    logic           btn_q, btn_d;
    logic           toggle_q, toggle_d;
    logic [31:0]    timer_q, timer_d;
    logic           vblank_q, vblank_d;
    fade_state_t    state_q, state_d;
    logic [1:0]     target_q, target_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [1:0]     dim_q, dim_d;
    logic           frame_tick;

    assign frame_tick = vid.vblank_in & ~vblank_q;

    always_comb begin
        btn_d    = pause_btn;
        toggle_d = toggle_q ^ (pause_btn & ~btn_q);
        vblank_d = vid.vblank_in;

        // Only the user toggle counts toward dimming; timer saturates at the threshold
        timer_d = timer_q;
        if (!toggle_q)
            timer_d = '0;
        else if (timer_q < DIM_CYCLES)
            timer_d = timer_q + 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        fcnt_d   = fcnt_q;
        unique case (state_q)
            FS_RUN: begin
                target_d = '0;
                fcnt_d   = '0;
                if (toggle_q)
                    state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (timer_q == DIM_CYCLES)
                    state_d = FS_FADE;
            end
            FS_FADE: begin
                if (frame_tick) begin
                    if (fcnt_q == FADE_LAST) begin
                        fcnt_d   = '0;
                        target_d = target_q + 2'd1;
                        if (target_q + 2'd1 == MAX_DIM_L)
                            state_d = FS_DIMMED;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            FS_DIMMED: state_d = FS_DIMMED;
            default:   state_d = FS_RUN;
        endcase

        // Unpause overrides everything, including a coincident frame tick
        if (!toggle_q) begin
            state_d  = FS_RUN;
            target_d = '0;
            fcnt_d   = '0;
        end

        // Brightness changes only at a frame boundary
        dim_d = frame_tick ? target_d : dim_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= 1'b0;
            toggle_q <= 1'b0;
            timer_q  <= '0;
            vblank_q <= 1'b0;
            state_q  <= FS_RUN;
            target_q <= '0;
            fcnt_q   <= '0;
            dim_q    <= '0;
        end else begin
            btn_q    <= btn_d;
            toggle_q <= toggle_d;
            timer_q  <= timer_d;
            vblank_q <= vblank_d;
            state_q  <= state_d;
            target_q <= target_d;
            fcnt_q   <= fcnt_d;
            dim_q    <= dim_d;
        end
    end

    assign pause     = hs_access | toggle_q | (osd_status & osd_pause_en);
    assign dim_level = dim_q;

    rgb332_dim u_dim (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .ce         (vid.ce_pix),
        .shift      (dim_q),
        .rgb_in     (vid.rgb_in),
        .hblank_in  (vid.hblank_in),
        .vblank_in  (vid.vblank_in),
        .hs_in      (vid.hs_in),
        .vs_in      (vid.vs_in),
        .rgb_out    (vid.rgb_out),
        .hblank_out (vid.hblank_out),
        .vblank_out (vid.vblank_out),
        .hs_out     (vid.hs_out),
        .vs_out     (vid.vs_out)
    );

endmodule
